// File: rtl/vga_cfg_pkg.sv
// Shared types and constants for the VGA configuration sequencer.
package vga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        FINISH
    } state_t;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    localparam int MAX_REGS = 16;

endpackage

// File: rtl/vga_cfg_sequencer.sv
// AXI4-Lite master that writes C_NUM_REGS register images into a VGA IP and,
// when VGA_CFG_READBACK_EN is defined, reads each one back and compares it.
module vga_cfg_sequencer
    import vga_cfg_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_BASE_ADDR        = 0,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            start,
    input  logic [C_NUM_REGS*32-1:0]        cfg_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [3:0]                      err_index,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int         IMG_W = MAX_REGS * 32;
    localparam logic [3:0] LAST  = 4'(C_NUM_REGS - 1);

`ifdef VGA_CFG_READBACK_EN
    localparam state_t WR_EXIT = RD_ADDR;
`else
    localparam state_t WR_EXIT = FINISH;
`endif

    state_t                         state, state_d;
    logic [3:0]                     k, k_d;
    logic                           aw_done, aw_done_d;
    logic                           w_done, w_done_d;
    logic                           err_q, err_d;
    logic [3:0]                     eidx, eidx_d;
    logic                           load;
    logic [IMG_W-1:0]               img;
    logic [31:0]                    img_k;
    logic [C_M_AXI_ADDR_WIDTH-1:0]  addr_k;

    // Images are zero-padded to 16 slots so a 4-bit k always indexes in range.
    assign img_k  = img[{k, 5'd0} +: 32];
    assign addr_k = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR) + C_M_AXI_ADDR_WIDTH'({k, 2'b00});

    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_AWVALID = (state == WR_ADDR_DATA) && !aw_done;
    assign M_AXI_WVALID  = (state == WR_ADDR_DATA) && !w_done;
    assign M_AXI_AWADDR  = (state == WR_ADDR_DATA) ? addr_k : '0;
    assign M_AXI_WDATA   = (state == WR_ADDR_DATA) ? img_k : '0;
    assign M_AXI_BREADY  = (state == WR_RESP);

`ifdef VGA_CFG_READBACK_EN
    assign M_AXI_ARVALID = (state == RD_ADDR);
    assign M_AXI_ARADDR  = (state == RD_ADDR) ? addr_k : '0;
    assign M_AXI_RREADY  = (state == RD_DATA);
`else
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_RREADY  = 1'b0;
    logic unused_rd;
    assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

    assign busy      = (state != IDLE) && (state != FINISH);
    assign done      = (state == FINISH) && !err_q;
    assign error     = err_q;
    assign err_index = eidx;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            k       <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
            eidx    <= '0;
            img     <= '0;
        end else begin
            state   <= state_d;
            k       <= k_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
            err_q   <= err_d;
            eidx    <= eidx_d;
            if (load)
                img <= IMG_W'(cfg_data);
        end
    end

    always_comb begin
        state_d   = state;
        k_d       = k;
        aw_done_d = aw_done;
        w_done_d  = w_done;
        err_d     = err_q;
        eidx_d    = eidx;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    err_d     = 1'b0;
                    eidx_d    = '0;
                    k_d       = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_ADDR_DATA;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W complete independently; move on once both have.
                aw_done_d = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
                w_done_d  = w_done | (M_AXI_WVALID & M_AXI_WREADY);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != AXI_OKAY) begin
                        err_d   = 1'b1;
                        eidx_d  = k;
                        state_d = FINISH;
                    end else if (k == LAST) begin
                        k_d     = '0;
                        state_d = WR_EXIT;
                    end else begin
                        k_d     = k + 4'd1;
                        state_d = WR_ADDR_DATA;
                    end
                end
            end
`ifdef VGA_CFG_READBACK_EN
            RD_ADDR: begin
                if (M_AXI_ARREADY)
                    state_d = RD_DATA;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    if (M_AXI_RRESP != AXI_OKAY || M_AXI_RDATA != img_k) begin
                        err_d   = 1'b1;
                        eidx_d  = k;
                        state_d = FINISH;
                    end else if (k == LAST) begin
                        k_d     = '0;
                        state_d = FINISH;
                    end else begin
                        k_d     = k + 4'd1;
                        state_d = RD_ADDR;
                    end
                end
            end
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vga_cfg_sequencer.sv
// Directed bench for vga_cfg_sequencer with a negedge-driven AXI4-Lite slave model.
module tb_vga_cfg_sequencer;
    import vga_cfg_pkg::*;

    localparam int AW = 4;
    localparam int NR = 4;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              start = 1'b0;
    logic [NR*32-1:0]  cfg_data = '0;
    logic              busy, done, error;
    logic [3:0]        err_index;
    logic [AW-1:0]     M_AXI_AWADDR, M_AXI_ARADDR;
    logic [2:0]        M_AXI_AWPROT, M_AXI_ARPROT;
    logic              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
    logic [31:0]       M_AXI_WDATA;
    logic [3:0]        M_AXI_WSTRB;
    logic              M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
    logic              M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
    logic [1:0]        M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
    logic [31:0]       M_AXI_RDATA = '0;

    vga_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(32), .C_BASE_ADDR(0), .C_NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0, checks = 0, cyc = 0;
    int aw_delay = 0, w_delay = 0, berr_reg = -1, rbad_reg = -1;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, aw_cnt = 0, w_cnt = 0;
    int done_n = 0, done_cyc = 0, last_b_cyc = 0, viol_n = 0;
    bit ar_seen = 1'b0;
    logic [AW-1:0] aw_log [16];
    logic [31:0]   w_log  [16];
    logic [AW-1:0] ar_log [16];
    logic [31:0]   exp_img [NR];

    always @(posedge ACLK) cyc++;

    // Slave and monitor: readies/responses change on negedge, DUT samples on posedge.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
            M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
            aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; aw_cnt = 0; w_cnt = 0;
            done_n = 0; viol_n = 0; ar_seen = 1'b0;
        end else begin
            if (done) begin done_n++; done_cyc = cyc; end
            if (M_AXI_ARVALID) ar_seen = 1'b1;
            if (M_AXI_AWREADY) begin
                M_AXI_AWREADY = 1'b0;
                if (M_AXI_AWVALID) viol_n++;
            end else if (M_AXI_AWVALID) begin
                if (aw_cnt >= aw_delay) begin
                    M_AXI_AWREADY = 1'b1;
                    if (aw_n < 16) aw_log[aw_n] = M_AXI_AWADDR;
                    aw_n++; aw_cnt = 0;
                end else aw_cnt++;
            end else if (aw_cnt > 0) viol_n++;
            if (M_AXI_WREADY) begin
                M_AXI_WREADY = 1'b0;
                if (M_AXI_WVALID) viol_n++;
            end else if (M_AXI_WVALID) begin
                if (w_cnt >= w_delay) begin
                    M_AXI_WREADY = 1'b1;
                    if (w_n < 16) w_log[w_n] = M_AXI_WDATA;
                    w_n++; w_cnt = 0;
                end else w_cnt++;
            end else if (w_cnt > 0) viol_n++;
            if (M_AXI_BVALID) M_AXI_BVALID = 1'b0;
            else if (aw_n > b_n && w_n > b_n && M_AXI_BREADY) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = (b_n == berr_reg) ? AXI_SLVERR : AXI_OKAY;
                last_b_cyc   = cyc + 1;
                b_n++;
            end
            if (M_AXI_ARREADY) M_AXI_ARREADY = 1'b0;
            else if (M_AXI_ARVALID) begin
                M_AXI_ARREADY = 1'b1;
                if (ar_n < 16) ar_log[ar_n] = M_AXI_ARADDR;
                ar_n++;
            end
            if (M_AXI_RVALID) M_AXI_RVALID = 1'b0;
            else if (ar_n > r_n && M_AXI_RREADY) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RRESP  = AXI_OKAY;
                M_AXI_RDATA  = (r_n == rbad_reg) ? 32'hDEAD : ((r_n < NR) ? exp_img[r_n] : 32'h0);
                r_n++;
            end
        end
    end

    task automatic do_reset();
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic load_cfg(input logic [31:0] base);
        for (int i = 0; i < NR; i++) begin
            exp_img[i] = base + 32'(i + 1);
            cfg_data[32*i +: 32] = exp_img[i];
        end
    endtask

    task automatic run_pass(input bit restart);
        int t;
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        if (restart) begin
            repeat (3) @(negedge ACLK);
            start = 1'b1;
            @(negedge ACLK); start = 1'b0;
        end
        t = 0;
        while (done_n == 0 && error !== 1'b1 && t < 400) begin
            @(negedge ACLK); t++;
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL pass_timeout: waited %0d cycles, required done or error", t);
        end
        repeat (4) @(negedge ACLK);
    endtask

    task automatic check_writes(input int first, input string tag);
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (aw_log[first+i] !== AW'(4*i)) begin
                errors++;
                $display("FAIL %s_awaddr[%0d]: got %0h required %0h", tag, i, aw_log[first+i], 4*i);
            end
            checks++;
            if (w_log[first+i] !== exp_img[i]) begin
                errors++;
                $display("FAIL %s_wdata[%0d]: got %0h required %0h", tag, i, w_log[first+i], exp_img[i]);
            end
        end
        checks++;
        if (viol_n !== 0) begin
            errors++;
            $display("FAIL %s_protocol: got %0d violations required 0", tag, viol_n);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 8'h00) begin
            errors++;
            $display("FAIL %s_ctrl: got %b required 00000000", tag,
                {busy, done, error, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        checks++;
        if ({err_index, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR} !== '0) begin
            errors++;
            $display("FAIL %s_data: got eidx=%0h awaddr=%0h wdata=%0h araddr=%0h required 0",
                tag, err_index, M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        check_idle_outputs("reset");
        checks++;
        if ({M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB} !== 10'b000_000_1111) begin
            errors++;
            $display("FAIL reset_const: got prot/strb %b required 0000001111", {M_AXI_AWPROT, M_AXI_ARPROT, M_AXI_WSTRB});
        end
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    task automatic test_basic();
        do_reset();
        aw_delay = 0; w_delay = 0; berr_reg = -1; rbad_reg = -1;
        load_cfg(32'h0);
        run_pass(1'b1);
        check_writes(0, "basic");
        checks++;
        if (aw_n !== NR || b_n !== NR) begin
            errors++;
            $display("FAIL basic_count: got aw=%0d b=%0d required %0d", aw_n, b_n, NR);
        end
        checks++;
        if (done_n !== 1 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done_n=%0d error=%b required 1/0", done_n, error);
        end
`ifdef VGA_CFG_READBACK_EN
        checks++;
        if (ar_n !== NR || ar_log[3] !== AW'(12) || ar_log[0] !== AW'(0)) begin
            errors++;
            $display("FAIL basic_reads: got ar=%0d a0=%0h a3=%0h required 4/0/c", ar_n, ar_log[0], ar_log[3]);
        end
`else
        checks++;
        if (ar_seen !== 1'b0) begin
            errors++;
            $display("FAIL basic_no_ar: got arvalid seen=%b required 0", ar_seen);
        end
        checks++;
        if (done_cyc !== last_b_cyc) begin
            errors++;
            $display("FAIL basic_done_timing: got cycle %0d required %0d", done_cyc, last_b_cyc);
        end
`endif
    endtask

    task automatic test_skew();
        for (int s = 0; s < 2; s++) begin
            do_reset();
            aw_delay = (s == 0) ? 3 : 0;
            w_delay  = (s == 0) ? 0 : 3;
            load_cfg(32'hA5A5_0000 + 32'(s << 8));
            run_pass(1'b0);
            check_writes(0, (s == 0) ? "skew_aw" : "skew_w");
            checks++;
            if (b_n !== NR || done_n !== 1) begin
                errors++;
                $display("FAIL skew_b_count[%0d]: got b=%0d done_n=%0d required %0d/1", s, b_n, done_n, NR);
            end
        end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_bresp_err();
        do_reset();
        berr_reg = 2;
        load_cfg(32'h1000);
        run_pass(1'b0);
        checks++;
        if (error !== 1'b1 || err_index !== 4'd2) begin
            errors++;
            $display("FAIL bresp_err: got error=%b idx=%0d required 1/2", error, err_index);
        end
        checks++;
        if (done_n !== 0 || b_n !== 3 || aw_n !== 3 || ar_n !== 0) begin
            errors++;
            $display("FAIL bresp_stop: got done=%0d b=%0d aw=%0d ar=%0d required 0/3/3/0", done_n, b_n, aw_n, ar_n);
        end
    endtask

    task automatic test_back_to_back();
        berr_reg = -1;
        load_cfg(32'h2000);
        run_pass(1'b0);
        checks++;
        if (error !== 1'b0 || done_n !== 1 || b_n !== 7) begin
            errors++;
            $display("FAIL b2b_clear: got error=%b done=%0d b=%0d required 0/1/7", error, done_n, b_n);
        end
        check_writes(3, "b2b");
    endtask

    task automatic test_rdata_err();
`ifdef VGA_CFG_READBACK_EN
        do_reset();
        rbad_reg = 1;
        load_cfg(32'h3000);
        run_pass(1'b0);
        checks++;
        if (error !== 1'b1 || err_index !== 4'd1 || ar_n !== 2 || done_n !== 0) begin
            errors++;
            $display("FAIL rdata_err: got error=%b idx=%0d ar=%0d done=%0d required 1/1/2/0",
                error, err_index, ar_n, done_n);
        end
        rbad_reg = -1;
`endif
    endtask

    task automatic test_mid_reset();
        int t;
        do_reset();
        w_delay = 5;
        load_cfg(32'h4000);
        @(negedge ACLK); start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        t = 0;
        while (!(M_AXI_WVALID === 1'b1 && M_AXI_AWADDR === AW'(4)) && t < 100) begin
            @(negedge ACLK); t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL midrst_wait: waited %0d cycles, required WVALID on register 1", t);
        end
        ARESETN = 1'b0;
        #1;
        check_idle_outputs("midrst");
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        w_delay = 0;
        @(negedge ACLK);
        run_pass(1'b0);
        check_writes(0, "midrst_new");
        checks++;
        if (done_n !== 1 || b_n !== NR) begin
            errors++;
            $display("FAIL midrst_done: got done=%0d b=%0d required 1/%0d", done_n, b_n, NR);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_bresp_err();
        test_back_to_back();
        test_rdata_err();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
